// File: rtl/ysyx_24080006_axi_arbiter_if.sv
// AXI4-Lite channel bundle shared by the IFU, LSU and memory port.
// master drives requests; slave drives ready/response.
interface ysyx_24080006_axi;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready
    );

    modport slave (
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/ysyx_24080006_axi_arbiter.sv
// IFU/LSU arbiter onto the single AXI4-Lite memory port, one transaction at a time.
// Define YSYX_24080006_ARB_RR_EN for round-robin IFU-vs-LSU selection.
module ysyx_24080006_axi_arbiter (
    input  logic             clock,
    input  logic             reset,
    ysyx_24080006_axi.slave  axi_ifu,
    ysyx_24080006_axi.slave  axi_lsu,
    ysyx_24080006_axi.master axi_mem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } state_e;

    state_e r_state;
    state_e w_next;

    logic w_ifu_req;
    logic w_lsu_rd;
    logic w_lsu_wr;
    logic w_lsu_req;
    logic w_lsu_win;
    logic w_rd_done;
    logic w_wr_done;
    logic w_unused_ifu;

    assign w_ifu_req = axi_ifu.arvalid;
    assign w_lsu_rd  = axi_lsu.arvalid;
    assign w_lsu_wr  = axi_lsu.awvalid;
    assign w_lsu_req = w_lsu_rd | w_lsu_wr;
    assign w_rd_done = axi_mem.rvalid & axi_mem.rready;
    assign w_wr_done = axi_mem.bvalid & axi_mem.bready;

    // IFU is read-only; its write channels are never routed
    assign w_unused_ifu = ^{axi_ifu.awaddr, axi_ifu.awvalid,
                            axi_ifu.wdata, axi_ifu.wstrb,
                            axi_ifu.wvalid, axi_ifu.bready};

`ifdef YSYX_24080006_ARB_RR_EN
    logic r_last_lsu;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_lsu <= 1'b0;
        end else if (r_state == IDLE && w_next != IDLE) begin
            r_last_lsu <= (w_next != RD_IFU);
        end
    end

    assign w_lsu_win = w_lsu_req & (~w_ifu_req | ~r_last_lsu);
`else
    assign w_lsu_win = w_lsu_req;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_lsu_win) begin
                    w_next = w_lsu_wr ? WR_LSU : RD_LSU;
                end else if (w_ifu_req) begin
                    w_next = RD_IFU;
                end
            end
            RD_IFU, RD_LSU: begin
                if (w_rd_done) w_next = IDLE;
            end
            WR_LSU: begin
                if (w_wr_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        axi_mem.araddr  = axi_lsu.araddr;
        axi_mem.arvalid = 1'b0;
        axi_mem.rready  = 1'b0;
        axi_mem.awaddr  = axi_lsu.awaddr;
        axi_mem.awvalid = 1'b0;
        axi_mem.wdata   = axi_lsu.wdata;
        axi_mem.wstrb   = axi_lsu.wstrb;
        axi_mem.wvalid  = 1'b0;
        axi_mem.bready  = 1'b0;

        axi_ifu.arready = 1'b0;
        axi_ifu.rdata   = axi_mem.rdata;
        axi_ifu.rresp   = axi_mem.rresp;
        axi_ifu.rvalid  = 1'b0;
        axi_ifu.awready = 1'b0;
        axi_ifu.wready  = 1'b0;
        axi_ifu.bresp   = 2'b00;
        axi_ifu.bvalid  = 1'b0;

        axi_lsu.arready = 1'b0;
        axi_lsu.rdata   = axi_mem.rdata;
        axi_lsu.rresp   = axi_mem.rresp;
        axi_lsu.rvalid  = 1'b0;
        axi_lsu.awready = 1'b0;
        axi_lsu.wready  = 1'b0;
        axi_lsu.bresp   = axi_mem.bresp;
        axi_lsu.bvalid  = 1'b0;

        unique case (r_state)
            RD_IFU: begin
                axi_mem.araddr  = axi_ifu.araddr;
                axi_mem.arvalid = axi_ifu.arvalid;
                axi_ifu.arready = axi_mem.arready;
                axi_ifu.rvalid  = axi_mem.rvalid;
                axi_mem.rready  = axi_ifu.rready;
            end
            RD_LSU: begin
                axi_mem.arvalid = axi_lsu.arvalid;
                axi_lsu.arready = axi_mem.arready;
                axi_lsu.rvalid  = axi_mem.rvalid;
                axi_mem.rready  = axi_lsu.rready;
            end
            WR_LSU: begin
                axi_mem.awvalid = axi_lsu.awvalid;
                axi_lsu.awready = axi_mem.awready;
                axi_mem.wvalid  = axi_lsu.wvalid;
                axi_lsu.wready  = axi_mem.wready;
                axi_lsu.bvalid  = axi_mem.bvalid;
                axi_mem.bready  = axi_lsu.bready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
// Scoreboard bench for ysyx_24080006_axi_arbiter: directed IFU/LSU traffic
// against a small memory model; a negedge monitor checks every handshake.
module tb_ysyx_24080006_axi_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_24080006_axi ifu ();
    ysyx_24080006_axi lsu ();
    ysyx_24080006_axi mem ();

    ysyx_24080006_axi_arbiter dut (
        .clock   (clock),
        .reset   (reset),
        .axi_ifu (ifu),
        .axi_lsu (lsu),
        .axi_mem (mem)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_ar[$];
    logic [31:0] q_aw[$];
    logic [35:0] q_w[$];
    logic [33:0] q_mresp[$];
    logic [1:0]  q_mbresp[$];
    logic [33:0] q_ifu_r[$];
    logic [33:0] q_lsu_r[$];
    logic [1:0]  q_lsu_b[$];

    logic flush    = 1'b0;
    logic ifu_done = 1'b0;
    logic lsu_done = 1'b0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    // Monitor: every handshake pops the scoreboard entry it must match
    always @(negedge clock) begin
        if (reset) begin
            if (mem.arvalid && mem.arready) begin
                if (q_ar.size() == 0) miss("mem_ar");
                else check("mem_ar", 64'(mem.araddr), 64'(q_ar.pop_front()));
            end
            if (mem.awvalid && mem.awready) begin
                if (q_aw.size() == 0) miss("mem_aw");
                else check("mem_aw", 64'(mem.awaddr), 64'(q_aw.pop_front()));
            end
            if (mem.wvalid && mem.wready) begin
                if (q_w.size() == 0) miss("mem_w");
                else check("mem_w", 64'({mem.wdata, mem.wstrb}),
                           64'(q_w.pop_front()));
            end
            if (ifu.rvalid && ifu.rready) begin
                if (q_ifu_r.size() == 0) miss("ifu_r");
                else check("ifu_r", 64'({ifu.rdata, ifu.rresp}),
                           64'(q_ifu_r.pop_front()));
            end
            if (lsu.rvalid && lsu.rready) begin
                if (q_lsu_r.size() == 0) miss("lsu_r");
                else check("lsu_r", 64'({lsu.rdata, lsu.rresp}),
                           64'(q_lsu_r.pop_front()));
            end
            if (lsu.bvalid && lsu.bready) begin
                if (q_lsu_b.size() == 0) miss("lsu_b");
                else check("lsu_b", 64'(lsu.bresp), 64'(q_lsu_b.pop_front()));
            end
        end
    end

    // Memory model: read data 3 cycles after AR, B once both AW and W landed
    initial begin
        mem.arready = 1'b1;
        mem.rvalid  = 1'b0;
        mem.rdata   = '0;
        mem.rresp   = '0;
        mem.awready = 1'b1;
        mem.wready  = 1'b1;
        mem.bvalid  = 1'b0;
        mem.bresp   = '0;
    end

    always begin
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
        static int   rd_cnt = -1;
        static logic got_aw = 1'b0;
        static logic got_w  = 1'b0;
        @(negedge clock);
        ar_hs = mem.arvalid && mem.arready;
        r_hs  = mem.rvalid && mem.rready;
        aw_hs = mem.awvalid && mem.awready;
        w_hs  = mem.wvalid && mem.wready;
        b_hs  = mem.bvalid && mem.bready;
        @(posedge clock);
        #1;
        if (flush) begin
            mem.rvalid  = 1'b0;
            mem.arready = 1'b1;
            rd_cnt      = -1;
            flush       = 1'b0;
        end
        if (r_hs) begin
            mem.rvalid  = 1'b0;
            mem.arready = 1'b1;
        end
        if (ar_hs) begin
            mem.arready = 1'b0;
            rd_cnt      = 3;
        end else if (rd_cnt > 0) begin
            rd_cnt--;
        end
        if (rd_cnt == 0) begin
            rd_cnt = -1;
            if (q_mresp.size() != 0) {mem.rdata, mem.rresp} = q_mresp.pop_front();
            mem.rvalid = 1'b1;
        end
        if (b_hs) begin
            mem.bvalid  = 1'b0;
            mem.awready = 1'b1;
            mem.wready  = 1'b1;
            got_aw      = 1'b0;
            got_w       = 1'b0;
        end
        if (aw_hs) begin
            mem.awready = 1'b0;
            got_aw      = 1'b1;
        end
        if (w_hs) begin
            mem.wready = 1'b0;
            got_w      = 1'b1;
        end
        if (got_aw && got_w && !mem.bvalid && !aw_hs && !w_hs) begin
            if (q_mbresp.size() != 0) mem.bresp = q_mbresp.pop_front();
            mem.bvalid = 1'b1;
        end
    end

    task automatic ifu_read(input logic [31:0] a);
        int t;
        logic hs;
        ifu.araddr  = a;
        ifu.arvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clock); hs = ifu.arready;
            @(posedge clock); #1; t++;
        end while (!hs && t < 100);
        ifu.arvalid = 1'b0;
        if (!hs) miss("ifu_ar_timeout");
        t = 0;
        do begin
            @(negedge clock); hs = ifu.rvalid;
            @(posedge clock); #1; t++;
        end while (!hs && t < 100);
        if (!hs) miss("ifu_r_timeout");
        ifu_done = 1'b1;
    endtask

    task automatic lsu_read(input logic [31:0] a);
        int t;
        logic hs;
        lsu.araddr  = a;
        lsu.arvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clock); hs = lsu.arready;
            @(posedge clock); #1; t++;
        end while (!hs && t < 100);
        lsu.arvalid = 1'b0;
        if (!hs) miss("lsu_ar_timeout");
        t = 0;
        do begin
            @(negedge clock); hs = lsu.rvalid;
            @(posedge clock); #1; t++;
        end while (!hs && t < 100);
        if (!hs) miss("lsu_r_timeout");
        lsu_done = 1'b1;
    endtask

    task automatic lsu_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic w_first);
        int t;
        logic aw_hs, w_hs, hs;
        lsu.awaddr = a;
        lsu.wdata  = d;
        lsu.wstrb  = s;
        lsu.wvalid = 1'b1;
        if (w_first) begin
            @(posedge clock); #1;
        end
        lsu.awvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clock);
            aw_hs = lsu.awvalid && lsu.awready;
            w_hs  = lsu.wvalid && lsu.wready;
            @(posedge clock); #1; t++;
            if (aw_hs) lsu.awvalid = 1'b0;
            if (w_hs) lsu.wvalid = 1'b0;
        end while ((lsu.awvalid || lsu.wvalid) && t < 100);
        if (lsu.awvalid || lsu.wvalid) miss("lsu_aw_w_timeout");
        lsu.awvalid = 1'b0;
        lsu.wvalid  = 1'b0;
        t = 0;
        do begin
            @(negedge clock); hs = lsu.bvalid;
            @(posedge clock); #1; t++;
        end while (!hs && t < 100);
        if (!hs) miss("lsu_b_timeout");
    endtask

    function automatic logic [14:0] quiet_vec();
        return {mem.arvalid, mem.awvalid, mem.wvalid, mem.rready, mem.bready,
                ifu.arready, ifu.rvalid, ifu.awready, ifu.wready, ifu.bvalid,
                lsu.arready, lsu.rvalid, lsu.awready, lsu.wready, lsu.bvalid};
    endfunction

    initial begin
        int t;
        ifu.araddr = '0; ifu.arvalid = 1'b0; ifu.rready = 1'b1;
        ifu.awaddr = '0; ifu.awvalid = 1'b0; ifu.wdata = '0;
        ifu.wstrb = '0; ifu.wvalid = 1'b0; ifu.bready = 1'b0;
        lsu.araddr = '0; lsu.arvalid = 1'b0; lsu.rready = 1'b1;
        lsu.awaddr = '0; lsu.awvalid = 1'b0; lsu.wdata = '0;
        lsu.wstrb = '0; lsu.wvalid = 1'b0; lsu.bready = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", 64'(quiet_vec()), 64'd0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        // IFU read only
        q_ar.push_back(32'h8000_0000);
        q_mresp.push_back({32'h0000_0413, 2'b00});
        q_ifu_r.push_back({32'h0000_0413, 2'b00});
        ifu_read(32'h8000_0000);
        check("turnaround_idle", 64'({mem.arvalid, mem.rready}), 64'd0);

        // LSU write, AW and W together
        q_aw.push_back(32'h8000_0100);
        q_w.push_back({32'hDEAD_BEEF, 4'hF});
        q_mbresp.push_back(2'b00);
        q_lsu_b.push_back(2'b00);
        lsu_write(32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0);
        @(posedge clock); #1;

        // Simultaneous IFU and LSU reads
`ifdef YSYX_24080006_ARB_RR_EN
        q_ar.push_back(32'h8000_0004);
        q_mresp.push_back({32'h0010_0093, 2'b00});
        q_ar.push_back(32'h8000_0200);
        q_mresp.push_back({32'h1234_5678, 2'b00});
`else
        q_ar.push_back(32'h8000_0200);
        q_mresp.push_back({32'h1234_5678, 2'b00});
        q_ar.push_back(32'h8000_0004);
        q_mresp.push_back({32'h0010_0093, 2'b00});
`endif
        q_ifu_r.push_back({32'h0010_0093, 2'b00});
        q_lsu_r.push_back({32'h1234_5678, 2'b00});
        ifu_done = 1'b0;
        lsu_done = 1'b0;
        fork
            ifu_read(32'h8000_0004);
            lsu_read(32'h8000_0200);
            begin
                int bad;
                int n;
                bad = 0;
                n = 0;
`ifdef YSYX_24080006_ARB_RR_EN
                while (!ifu_done && n < 200) begin
                    @(negedge clock);
                    if (lsu.arready) bad++;
                    n++;
                end
`else
                while (!lsu_done && n < 200) begin
                    @(negedge clock);
                    if (ifu.arready) bad++;
                    n++;
                end
`endif
                check("loser_arready_low", 64'(bad), 64'd0);
            end
        join
        @(posedge clock); #1;

        // SLVERR on LSU read, IFU read pending behind it
        q_ar.push_back(32'h8000_0300);
        q_mresp.push_back({32'hBAD0_0000, 2'b10});
        q_lsu_r.push_back({32'hBAD0_0000, 2'b10});
        q_ar.push_back(32'h8000_0008);
        q_mresp.push_back({32'h0000_0513, 2'b00});
        q_ifu_r.push_back({32'h0000_0513, 2'b00});
        fork
            lsu_read(32'h8000_0300);
            begin
                @(posedge clock); #1;
                ifu_read(32'h8000_0008);
            end
        join
        @(posedge clock); #1;

        // LSU write, W one cycle before AW, DECERR response
        q_aw.push_back(32'h8000_0104);
        q_w.push_back({32'h0000_CAFE, 4'h3});
        q_mbresp.push_back(2'b11);
        q_lsu_b.push_back(2'b11);
        lsu_write(32'h8000_0104, 32'h0000_CAFE, 4'h3, 1'b1);
        @(posedge clock); #1;

        // Reset while RD_IFU awaits rvalid
        q_ar.push_back(32'h8000_0010);
        q_mresp.push_back({32'hFFFF_FFFF, 2'b00});
        ifu.araddr  = 32'h8000_0010;
        ifu.arvalid = 1'b1;
        #1;
        check("lat_same_cycle", 64'(mem.arvalid), 64'd0);
        @(posedge clock); #1;
        check("lat_next_cycle", 64'({mem.arvalid, ifu.arready, mem.araddr}),
              64'({1'b1, 1'b1, 32'h8000_0010}));
        @(posedge clock); #1;
        ifu.arvalid = 1'b0;
        check("rd_ifu_rready", 64'(mem.rready), 64'd1);
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        check("reset_mid_outputs", 64'(quiet_vec()), 64'd0);
        @(negedge clock) reset = 1'b1;
        t = 0;
        while (!mem.rvalid && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!mem.rvalid) miss("late_rvalid_timeout");
        else check("late_rvalid_blocked",
                   64'({mem.rvalid, mem.rready, ifu.rvalid}), 64'd4);
        flush = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Recovery read after reset
        q_ar.push_back(32'h8000_0014);
        q_mresp.push_back({32'h0000_8067, 2'b00});
        q_ifu_r.push_back({32'h0000_8067, 2'b00});
        ifu_read(32'h8000_0014);
        repeat (3) @(posedge clock);
        #1;

        check("scoreboard_empty",
              64'(q_ar.size() + q_aw.size() + q_w.size() + q_ifu_r.size()
                  + q_lsu_r.size() + q_lsu_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
